// File: rtl/scs8hd_dlytap_cal_if.sv
// Handshake bundle between the delay-line calibration controller and its user.
// Signal suffixes are from the controller's point of view.
interface scs8hd_dlytap_cal_if #(
  parameter int TAPW = 5
);
  logic            start_i;
  logic            late_i;
  logic [TAPW-1:0] tap_o;
  logic            busy_o;
  logic            done_o;
  logic            locked_o;
  logic            err_o;

  modport master (
    output start_i, late_i,
    input  tap_o, busy_o, done_o, locked_o, err_o
  );

  modport slave (
    input  start_i, late_i,
    output tap_o, busy_o, done_o, locked_o, err_o
  );
endinterface

// File: rtl/scs8hd_dlytap_cal.sv
// Tapped delay-line calibration: linear search for the first tap reading LATE, then hold it.
// Define SCS8HD_DLYTAP_TRACK_EN to keep tracking drift after lock with a 2-result hysteresis.
module scs8hd_dlytap_cal #(
  parameter int TAPW       = 5,
  parameter int SETTLE_CYC = 4,
  parameter int NSAMP      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  scs8hd_dlytap_cal_if.slave    bus
);

  // state   | meaning
  // IDLE    | after reset, waiting for START
  // SETTLE  | tap just changed, letting the line settle
  // MEASURE | collecting NSAMP LATE samples
  // DECIDE  | majority vote: lock, step tap, or fail
  // LOCK    | tap found and held (tracked when enabled)
  // FAIL    | no tap read late
  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, DECIDE, LOCK, FAIL} state_t;

  localparam int CMAX = (SETTLE_CYC > NSAMP) ? SETTLE_CYC : NSAMP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int OW   = $clog2(NSAMP + 1);

  localparam logic [TAPW-1:0] TAP_MAX   = '1;
  localparam logic [CW-1:0]   SETTLE_LD = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0]   MEAS_LD   = CW'(NSAMP - 1);
  localparam logic [OW-1:0]   HALF      = OW'(NSAMP / 2);

  state_t          state_q, state_d;
  logic [TAPW-1:0] tap_q, tap_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   ones_q, ones_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            locked_q, locked_d;
  logic            err_q, err_d;

`ifdef SCS8HD_DLYTAP_TRACK_EN
  logic            trk_meas_q, trk_meas_d;
  logic [1:0]      hyst_q, hyst_d;   // {previous result valid, previous result late}
  logic            trk_late;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tap_q    <= '0;
      cnt_q    <= '0;
      ones_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef SCS8HD_DLYTAP_TRACK_EN
      trk_meas_q <= 1'b0;
      hyst_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      cnt_q    <= cnt_d;
      ones_q   <= ones_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      locked_q <= locked_d;
      err_q    <= err_d;
`ifdef SCS8HD_DLYTAP_TRACK_EN
      trk_meas_q <= trk_meas_d;
      hyst_q     <= hyst_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    cnt_d    = cnt_q;
    ones_d   = ones_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    locked_d = locked_q;
    err_d    = err_q;
`ifdef SCS8HD_DLYTAP_TRACK_EN
    trk_meas_d = trk_meas_q;
    hyst_d     = hyst_q;
    trk_late   = 1'b0;
`endif
    case (state_q)
      IDLE, LOCK, FAIL: begin
        if (bus.start_i) begin
          tap_d    = '0;
          busy_d   = 1'b1;
          locked_d = 1'b0;
          err_d    = 1'b0;
          cnt_d    = SETTLE_LD;
          state_d  = SETTLE;
        end
`ifdef SCS8HD_DLYTAP_TRACK_EN
        else if (state_q == LOCK) begin
          if (!trk_meas_q) begin
            if (cnt_q == '0) begin
              trk_meas_d = 1'b1;
              cnt_d      = MEAS_LD;
              ones_d     = '0;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end else begin
            ones_d = ones_q + OW'(bus.late_i);
            if (cnt_q == '0) begin
              trk_meas_d = 1'b0;
              cnt_d      = SETTLE_LD;
              trk_late   = (ones_d > HALF);
              if (!hyst_q[1]) begin
                hyst_d = {1'b1, trk_late};
              end else begin
                hyst_d = '0;
                // Only two agreeing results in a row move the tap.
                if (hyst_q[0] == trk_late) begin
                  if (trk_late) begin
                    if (tap_q != '0) tap_d = tap_q - 1'b1;
                  end else if (tap_q == TAP_MAX) begin
                    err_d = 1'b1;
                  end else begin
                    tap_d = tap_q + 1'b1;
                  end
                end
              end
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
`endif
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          cnt_d   = MEAS_LD;
          ones_d  = '0;
          state_d = MEASURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MEASURE: begin
        ones_d = ones_q + OW'(bus.late_i);
        if (cnt_q == '0) state_d = DECIDE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DECIDE: begin
        if (ones_q > HALF) begin
          locked_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          cnt_d    = SETTLE_LD;
          state_d  = LOCK;
`ifdef SCS8HD_DLYTAP_TRACK_EN
          trk_meas_d = 1'b0;
          hyst_d     = '0;
`endif
        end else if (tap_q != TAP_MAX) begin
          tap_d   = tap_q + 1'b1;
          cnt_d   = SETTLE_LD;
          state_d = SETTLE;
        end else begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FAIL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tap_o    = tap_q;
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.locked_o = locked_q;
  assign bus.err_o    = err_q;

endmodule

// File: tb/tb_scs8hd_dlytap_cal.sv
// Self-checking bench for scs8hd_dlytap_cal (default build, tracking disabled).
module tb_scs8hd_dlytap_cal;
  logic clk = 1'b0;
  logic rst;

  scs8hd_dlytap_cal_if #(.TAPW(5)) bus ();

  scs8hd_dlytap_cal #(.TAPW(5), .SETTLE_CYC(4), .NSAMP(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit lt [32][3];   // LATE value presented for sample s of the measurement at tap t

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int tap, input int busy,
                            input int done, input int locked, input int err);
    chk({tag, ".tap"},    32'(bus.tap_o),    tap);
    chk({tag, ".busy"},   32'(bus.busy_o),   busy);
    chk({tag, ".done"},   32'(bus.done_o),   done);
    chk({tag, ".locked"}, 32'(bus.locked_o), locked);
    chk({tag, ".err"},    32'(bus.err_o),    err);
  endtask

  // Model: every iteration is 8 edges (4 settle, 3 samples, 1 decide) counted from the START edge.
  task automatic run_cal(input int repulse_e, input int abort_e, output int done_e, output int final_tap);
    int  ones = 0;
    int  k, p;
    bit  fin = 1'b0;
    int  exp_locked = 0;
    int  exp_err = 0;
    done_e    = -1;
    final_tap = 0;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.late_i  = 1'($urandom);
    @(posedge clk); #1;
    check_outs("start", 0, 1, 0, 0, 0);
    for (int e = 1; e <= 300 && !fin; e++) begin
      k = (e - 1) / 8;
      p = (e - 1) % 8 + 1;
      @(negedge clk);
      bus.start_i = (e == repulse_e);
      if (p >= 5 && p <= 7) begin
        bus.late_i = lt[k][p-5];
        ones += int'(lt[k][p-5]);
      end else begin
        bus.late_i = 1'($urandom);
      end
      @(posedge clk); #1;
      if (p == 8 && ones > 1) begin
        check_outs("lock", k, 0, 1, 1, 0);
        done_e = e; final_tap = k; exp_locked = 1; fin = 1'b1;
      end else if (p == 8 && k == 31) begin
        check_outs("fail", 31, 0, 1, 0, 1);
        done_e = e; final_tap = 31; exp_err = 1; fin = 1'b1;
      end else begin
        if (p == 8) ones = 0;
        check_outs("run", e / 8, 1, 0, 0, 0);
        if (e == abort_e) fin = 1'b1;
      end
    end
    if (abort_e < 0) begin
      repeat (12) begin
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.late_i  = 1'($urandom);
        @(posedge clk); #1;
        check_outs("hold", final_tap, 0, 0, exp_locked, exp_err);
      end
    end
  endtask

  task automatic fill_threshold(input int thr, input int noise_pct);
    for (int t = 0; t < 32; t++)
      for (int s = 0; s < 3; s++)
        lt[t][s] = (t >= thr) ? (32'($urandom_range(99, 0)) >= 32'(noise_pct))
                              : (32'($urandom_range(99, 0)) <  32'(noise_pct));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int de, ft;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.late_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset in the middle of the tap-7 measurement.
    fill_threshold(40, 0);
    run_cal(-1, 62, de, ft);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outs("rst_async", 0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;

    // Clean threshold at tap 5: DONE at edge 48.
    fill_threshold(5, 0);
    run_cal(-1, -1, de, ft);
    chk("thr5.done_edge", de, 48);
    chk("thr5.tap", ft, 5);

    // LATE never asserted: fail at edge 256.
    fill_threshold(40, 0);
    run_cal(-1, -1, de, ft);
    chk("fail.done_edge", de, 256);
    chk("fail.tap", ft, 31);

    // Majority vote: 1,0,0 at tap 2 is early; 1,1,0 at tap 3 is late.
    fill_threshold(40, 0);
    lt[2][0] = 1'b1; lt[2][1] = 1'b0; lt[2][2] = 1'b0;
    lt[3][0] = 1'b1; lt[3][1] = 1'b1; lt[3][2] = 1'b0;
    run_cal(-1, -1, de, ft);
    chk("vote.done_edge", de, 32);
    chk("vote.tap", ft, 3);

    // START re-pulsed at edge 20 while busy is ignored.
    fill_threshold(5, 0);
    run_cal(20, -1, de, ft);
    chk("repulse.done_edge", de, 48);
    chk("repulse.tap", ft, 5);

    // Random thresholds with noisy samples.
    for (int r = 0; r < 8; r++) begin
      fill_threshold(int'($urandom_range(34, 0)), 15);
      run_cal((r % 2 == 1) ? int'($urandom_range(30, 1)) : -1, -1, de, ft);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/scs8hd_dlytap_cal.md
# scs8hd_dlytap_cal

Calibration controller for a tapped delay line built from chained delay-gate cells. It drives the tap-select code of the line's output mux and reads back a registered phase-detector bit, LATE, which reports whether the selected delayed edge lands after the reference clock edge. It linearly searches for the first tap that reads late and then holds that code for the datapath. As a compile option it keeps tracking voltage and temperature drift after lock.

## Interface
- TAPW, 5: tap code width; the line has 2^TAPW taps and TAPMAX = 2^TAPW−1.
- SETTLE_CYC, 4: wait cycles after every tap change before sampling; must be ≥1.
- NSAMP, 3: LATE samples taken per measurement; must be odd and ≥1.
- CLK  in  1  sole clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle request to begin calibration.
- LATE  in  1  phase-detector result, already synchronous to CLK; 1 = delayed edge is late.
- TAP  out  TAPW  tap select to the delay-line mux.
- BUSY  out  1  calibration in progress.
- DONE  out  1  one-cycle pulse when calibration ends (lock or fail).
- LOCKED  out  1  a valid tap has been found.
- ERR  out  1  no tap read late, or the tracking loop saturated.

## Operation
- States: IDLE, SETTLE, MEASURE, DECIDE, LOCK, FAIL.
- Reset values: state=IDLE, TAP=0, BUSY=0, DONE=0, LOCKED=0, ERR=0, all counters 0.
- IDLE, LOCK or FAIL with START=1: set TAP=0, BUSY=1, LOCKED=0, ERR=0, then go to SETTLE.
- START is ignored while BUSY=1.
- SETTLE: count SETTLE_CYC cycles, then go to MEASURE.
- MEASURE: sample LATE on NSAMP consecutive cycles and count the ones. The result is late when ones > NSAMP/2 (majority). Then go to DECIDE.
- DECIDE, result late: go to LOCK; LOCKED=1, BUSY=0, DONE=1 for one cycle; TAP is held.
- DECIDE, result early and TAP<TAPMAX: TAP+1, go to SETTLE.
- DECIDE, result early and TAP=TAPMAX: go to FAIL; ERR=1, BUSY=0, DONE=1 for one cycle; TAP stays at TAPMAX.
- TAP changes only on entry to SETTLE. It never wraps.
- The ones counter is ⌈log2(NSAMP+1)⌉ bits wide and clears on MEASURE entry.

## Timing
- The START edge moves the FSM to SETTLE on the next cycle.
- Each tap iteration takes SETTLE_CYC + NSAMP + 1 cycles.
- A lock at tap k raises DONE (k+1)·(SETTLE_CYC+NSAMP+1) cycles after the edge that sampled START.
- With defaults, a lock at tap k raises DONE at edge 8·(k+1); a fail raises it at edge 256.
- LOCKED and ERR assert in the same cycle as DONE and stay asserted until the next START or RESET.
- RESET asserted at any point, including mid-iteration, returns everything to reset values immediately, with no clock needed.
- Outputs hold until the first CLK edge after RESET deasserts.

## Configuration
- SCS8HD_DLYTAP_TRACK_EN defined: LOCK repeats the SETTLE/MEASURE cycle internally with LATE sampled; BUSY stays 0 and no DONE pulse is issued.
  - Each result feeds a 2-bit hysteresis counter. Two consecutive early results increment TAP; two consecutive late results decrement TAP. A mixed pair clears the counter.
  - TAP saturates at 0 and TAPMAX. A requested step beyond TAPMAX sets ERR=1 while LOCKED stays 1.
  - START still restarts full calibration.
- Macro undefined: LOCK freezes TAP, LATE is ignored, and there is no hysteresis logic.

## Test plan
- RESET pulsed mid-MEASURE at tap 7 → TAP=0, BUSY/DONE/LOCKED/ERR=0 with no CLK edge; a new START then calibrates from tap 0.
- Defaults, LATE=1 iff TAP≥5, START at edge 0 → DONE pulse at edge 48, TAP=5, LOCKED=1, BUSY=0.
- LATE held 0 → DONE at edge 256, TAP=31, ERR=1, LOCKED=0.
- At tap 2, LATE samples 1,0,0 → step to tap 3; samples 1,1,0 at tap 3 → lock at TAP=3.
- START re-pulsed at edge 20 while BUSY → ignored; lock timing unchanged (TAP=5 at edge 48).
- TRACK_EN defined: after lock at 5, force two early measurements → TAP=6; then late, early, late → TAP stays 6; force early repeatedly at 31 → TAP=31, ERR=1, LOCKED=1.
